mdu_divider: RTL and testbench



---
 rtl/mdu_divider.sv | 167 ++++++++++++++++
 tb/tb_mdu_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider (signed/unsigned) for the MIPS execute stage.
// One quotient bit per cycle; sign fix-up and divide-by-zero results are applied on entry to DONE.
module mdu_divider #(
    parameter int WIDTH     = 32,
    parameter int ZERO_FAST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] final_quo;
    logic [WIDTH-1:0] final_rem;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;
    logic             dividend_neg;
    logic             divisor_neg;

    // Restoring step: acc shifts out dividend bits at the top and collects quotient bits at the bottom.
    always_comb begin
        shifted = {rem_q, acc_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            step_rem = shifted[WIDTH-1:0];
            step_acc = {acc_q[WIDTH-2:0], 1'b0};
        end else begin
            step_rem = trial[WIDTH-1:0];
            step_acc = {acc_q[WIDTH-2:0], 1'b1};
        end
        final_quo = neg_quo_q ? (~step_acc + 1'b1) : step_acc;
        final_rem = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
        // A zero divisor on the slow path must still report all-ones regardless of operand signs.
        if (zero_q) begin
            final_quo = '1;
        end
    end

    always_comb begin
        dividend_neg = signed_div & dividend[WIDTH-1];
        divisor_neg  = signed_div & divisor[WIDTH-1];
        abs_dividend = dividend_neg ? (~dividend + 1'b1) : dividend;
        abs_divisor  = divisor_neg  ? (~divisor + 1'b1)  : divisor;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !cancel) begin
                    rem_d     = '0;
                    acc_d     = abs_dividend;
                    dvs_d     = abs_divisor;
                    cnt_d     = '0;
                    neg_quo_d = dividend_neg ^ divisor_neg;
                    neg_rem_d = dividend_neg;
                    zero_d    = (divisor == '0);
                    if ((divisor == '0) && (ZERO_FAST != 0)) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        quo_d   = final_quo;
                        rmd_d   = final_rem;
                        dbz_d   = zero_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign ready       = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider: table of divides plus hand sequences for
// back-to-back, cancel, async reset, stray start and the slow divide-by-zero path.
module tb_mdu_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, signed_div, cancel;
    logic [31:0] dividend, divisor;
    logic        busy, ready, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        s_start, s_signed, s_cancel;
    logic [31:0] s_dividend, s_divisor;
    logic        s_busy, s_ready, s_dbz;
    logic [31:0] s_quotient, s_remainder;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_divider #(.WIDTH(32), .ZERO_FAST(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .signed_div(signed_div), .cancel(cancel),
        .dividend(dividend), .divisor(divisor), .busy(busy), .ready(ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    mdu_divider #(.WIDTH(32), .ZERO_FAST(0)) u_dut_slow (
        .clk(clk), .reset(reset), .start(s_start), .signed_div(s_signed), .cancel(s_cancel),
        .dividend(s_dividend), .divisor(s_divisor), .busy(s_busy), .ready(s_ready),
        .quotient(s_quotient), .remainder(s_remainder), .div_by_zero(s_dbz)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Issue one divide on the fast DUT and wait (bounded) for ready.
    // lat counts sampled cycles including the accepting edge.
    task automatic do_div(input bit sync, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
        if (sync) @(negedge clk);
        start      = 1'b1;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!ready && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic do_slow(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] q, output logic [31:0] r,
                           output logic dz);
        @(negedge clk);
        s_start    = 1'b1;
        s_signed   = sgn;
        s_dividend = a;
        s_divisor  = b;
        @(posedge clk); #1;
        s_start = 1'b0;
        lat     = 1;
        while (!s_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = s_quotient;
        r  = s_remainder;
        dz = s_dbz;
    endtask

    initial begin
        int          lat, busy_n;
        logic [31:0] q, r;
        logic        dz;
        int          seen;

        vecs[0]  = '{1'b0, 32'd7,        32'd2,        32'h00000003, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 33};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 33};
        vecs[5]  = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 1'b1, 1};
        vecs[6]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 1'b1, 1};
        vecs[7]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
        vecs[8]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
        vecs[10] = '{1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 33};
        vecs[11] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};

        reset = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
        dividend = '0; divisor = '0;
        s_start = 1'b0; s_signed = 1'b0; s_cancel = 1'b0; s_dividend = '0; s_divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_busy",  32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_q",     quotient, 32'd0);
        check("reset_r",     remainder, 32'd0);
        check("reset_dz",    32'(div_by_zero), 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_div(1'b1, vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_n, q, r, dz);
            check($sformatf("v%0d_q", i), q, vecs[i].q);
            check($sformatf("v%0d_r", i), r, vecs[i].r);
            check($sformatf("v%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].lat - 1));
            @(posedge clk); #1;
            check($sformatf("v%0d_ready_pulse", i), 32'(ready), 32'd0);
        end

        // Back-to-back: second start driven while the first result is in DONE.
        do_div(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat, busy_n, q, r, dz);
        check("b2b_first_q", q, 32'hFFFFFFFD);
        check("b2b_first_r", r, 32'hFFFFFFFF);
        do_div(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, lat, busy_n, q, r, dz);
        check("b2b_second_lat", 32'(lat), 32'd33);
        check("b2b_second_q", q, 32'hFFFFFFFD);
        check("b2b_second_r", r, 32'h00000001);

        // Cancel during CALC at cycle 10.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("cancel_busy_before", 32'(busy), 32'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy_after", 32'(busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("cancel_no_ready", 32'(seen), 32'd0);
        check("cancel_q_hold", quotient, 32'hFFFFFFFD);
        check("cancel_r_hold", remainder, 32'h00000001);

        do_div(1'b1, 1'b0, 32'd100, 32'd7, lat, busy_n, q, r, dz);
        check("after_cancel_q", q, 32'd14);
        check("after_cancel_r", r, 32'd2);
        @(posedge clk); #1;

        // cancel together with start in IDLE: nothing starts.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ready || busy) seen++;
        end
        check("cancel_start_idle", 32'(seen), 32'd0);
        check("cancel_start_q", quotient, 32'd14);

        // Stray start mid-CALC must not disturb the divide in flight.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd200; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_div = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stray_lat", 32'(lat), 32'd33);
        check("stray_q", quotient, 32'd28);
        check("stray_r", remainder, 32'd4);

        // Asynchronous reset in the middle of cycle 15.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("areset_busy",  32'(busy), 32'd0);
        check("areset_ready", 32'(ready), 32'd0);
        check("areset_q",     quotient, 32'd0);
        check("areset_r",     remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("areset_no_ready", 32'(seen), 32'd0);
        do_div(1'b1, 1'b0, 32'd9, 32'd3, lat, busy_n, q, r, dz);
        check("post_reset_q", q, 32'd3);
        check("post_reset_r", r, 32'd0);

        // Divide by zero on the full-length path.
        do_slow(1'b1, 32'd5, 32'd0, lat, q, r, dz);
        check("slow_s_lat", 32'(lat), 32'd33);
        check("slow_s_q", q, 32'hFFFFFFFF);
        check("slow_s_r", r, 32'd5);
        check("slow_s_dz", 32'(dz), 32'd1);
        do_slow(1'b0, 32'd5, 32'd0, lat, q, r, dz);
        check("slow_u_lat", 32'(lat), 32'd33);
        check("slow_u_q", q, 32'hFFFFFFFF);
        check("slow_u_r", r, 32'd5);
        check("slow_u_dz", 32'(dz), 32'd1);
        do_slow(1'b1, 32'hFFFFFFFB, 32'd0, lat, q, r, dz);
        check("slow_neg_q", q, 32'hFFFFFFFF);
        check("slow_neg_r", r, 32'hFFFFFFFB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
